// File: rtl/loader_pkg.sv
// Shared definitions for the ram_loader host bridge: command opcodes,
// response bytes and the command FSM state encoding.
package loader_pkg;

  localparam logic [7:0] OP_SET_ADDR = 8'h01;
  localparam logic [7:0] OP_WRITE    = 8'h02;
  localparam logic [7:0] OP_READ     = 8'h03;
  localparam logic [7:0] OP_RUN      = 8'h04;
  localparam logic [7:0] OP_HALT     = 8'h05;

  localparam logic [7:0] RSP_ERR = 8'hEE;
  localparam logic [7:0] RSP_ACK = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_WRITE,
    ST_RD_WAIT,
    ST_TX,
    ST_RESP
  } state_t;

endpackage

// File: rtl/loader_byte_pack.sv
// Four-byte little-endian shift register shared by address collection,
// write-data collection and read-data serialisation. Bytes shift in at the
// top so the first byte received ends up in bits [7:0]; bytes shift out from
// the bottom so the least significant byte leaves first. The 2-bit counter
// wraps after four shifts, so it is back at zero once a word is complete.
module loader_byte_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_in,
  input  logic        shift_out,
  input  logic        load,
  input  logic [7:0]  byte_in,
  input  logic [31:0] word_in,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  assign word_next = {byte_in, word_q[31:8]};
  assign word      = word_q;
  assign byte_out  = word_q[7:0];
  assign last      = (cnt_q == 2'd3);

  // Next word/count: parallel load wins, then assemble, then serialise.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load) begin
      word_d = word_in;
      cnt_d  = 2'd0;
    end else if (shift_in) begin
      word_d = word_next;
      cnt_d  = cnt_q + 2'd1;
    end else if (shift_out) begin
      word_d = {8'h00, word_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
    end else if (clear) begin
      cnt_d  = 2'd0;
    end
  end

  // Register the shift state; reset discards any partially assembled word.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= 32'h0;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Byte-stream host bridge driving the host-side RAM port and the core reset.
// Commands: SET_ADDR, WRITE, READ, RUN, HALT; unknown opcodes answer 0xEE.
// Define LOADER_ACK_EN to have SET_ADDR/WRITE/RUN/HALT answer 0xAA.
module ram_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int RAM_RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  mem_wr_en,
  output logic [3:0]            mem_wr_strobe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wr_data,
  input  logic [31:0]           mem_rd_data,
  output logic                  core_reset_n,
  output logic                  busy
);

`ifdef LOADER_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  localparam logic [1:0] RD_LAST = 2'(RAM_RD_LATENCY - 1);

  state_t                state_q, state_d;
  logic [31:0]           ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  core_run_q, core_run_d;
  logic [7:0]            resp_q, resp_d;
  logic [1:0]            rd_cnt_q, rd_cnt_d;

  logic        pk_clear, pk_shift_in, pk_shift_out, pk_load, pk_last;
  logic [31:0] pk_word, pk_word_next;
  logic [7:0]  pk_byte;
  logic        rx_fire, tx_fire;

  loader_byte_pack u_pack (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .shift_in  (pk_shift_in),
    .shift_out (pk_shift_out),
    .load      (pk_load),
    .byte_in   (rx_data),
    .word_in   (mem_rd_data),
    .word      (pk_word),
    .word_next (pk_word_next),
    .byte_out  (pk_byte),
    .last      (pk_last)
  );

  assign rx_ready = !reset && (state_q == ST_IDLE || state_q == ST_GET_ADDR ||
                               state_q == ST_GET_DATA);
  assign tx_valid = !reset && (state_q == ST_TX || state_q == ST_RESP);
  assign tx_data  = (state_q == ST_TX)   ? pk_byte :
                    (state_q == ST_RESP) ? resp_q  : 8'h00;
  assign mem_wr_en     = !reset && (state_q == ST_WRITE);
  assign mem_wr_strobe = mem_wr_en ? 4'hF : 4'h0;
  assign mem_wr_data   = pk_word;
  assign mem_addr      = mem_addr_q;
  assign core_reset_n  = core_run_q;
  assign busy          = (state_q != ST_IDLE);
  assign rx_fire       = rx_valid && rx_ready;
  assign tx_fire       = tx_valid && tx_ready;

  // Command FSM: decode, collect operands, touch RAM, then emit responses.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    core_run_d   = core_run_q;
    resp_d       = resp_q;
    rd_cnt_d     = rd_cnt_q;
    pk_clear     = 1'b0;
    pk_shift_in  = 1'b0;
    pk_shift_out = 1'b0;
    pk_load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pk_clear = 1'b1;
        if (rx_fire) begin
          case (rx_data)
            OP_SET_ADDR: state_d = ST_GET_ADDR;
            OP_WRITE:    state_d = ST_GET_DATA;
            OP_READ: begin
              rd_cnt_d = 2'd0;
              state_d  = ST_RD_WAIT;
            end
            OP_RUN, OP_HALT: begin
              core_run_d = (rx_data == OP_RUN);
              resp_d     = RSP_ACK;
              state_d    = ACK_EN ? ST_RESP : ST_IDLE;
            end
            default: begin
              resp_d  = RSP_ERR;
              state_d = ST_RESP;
            end
          endcase
        end
      end
      ST_GET_ADDR: begin
        if (rx_fire) begin
          pk_shift_in = 1'b1;
          if (pk_last) begin
            ptr_d   = pk_word_next;
            resp_d  = RSP_ACK;
            state_d = ACK_EN ? ST_RESP : ST_IDLE;
          end
        end
      end
      ST_GET_DATA: begin
        if (rx_fire) begin
          pk_shift_in = 1'b1;
          if (pk_last) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ptr_d   = ptr_q + 32'd4;
        resp_d  = RSP_ACK;
        state_d = ACK_EN ? ST_RESP : ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (rd_cnt_q == RD_LAST) begin
          pk_load = 1'b1;
          ptr_d   = ptr_q + 32'd4;
          state_d = ST_TX;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      ST_TX: begin
        if (tx_fire) begin
          pk_shift_out = 1'b1;
          if (pk_last) state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (tx_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; mem_addr tracks the next pointer so it always equals ptr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 32'h0;
      mem_addr_q <= '0;
      core_run_q <= 1'b0;
      resp_q     <= 8'h00;
      rd_cnt_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mem_addr_q <= ptr_d[ADDR_WIDTH+1:2];
      core_run_q <= core_run_d;
      resp_q     <= resp_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader. A command-level model predicts RAM
// writes and response bytes; a per-cycle monitor compares the DUT against
// those predictions. Honours LOADER_ACK_EN when predicting ack bytes.
module tb_ram_loader;

  localparam int AW  = 8;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          mem_wr_en;
  logic [3:0]    mem_wr_strobe;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;
  logic          core_reset_n;
  logic          busy;

  int nCompared = 0;
  int nMismatch = 0;

  logic [31:0] ram [256];
  logic        ramReady = 1'b0;
  logic [31:0] rd1, rd2;

  logic [31:0] mMem [256];
  logic [31:0] mPtr;
  logic        mCore;
  logic [7:0]  expTx[$];
  logic [39:0] expWr[$];
  logic [7:0]  txLog[$];
  logic [39:0] wrLog[$];

  logic        prevStall = 1'b0;
  logic [7:0]  prevData = 8'h00;
  logic [39:0] cmpWr;
  logic [7:0]  cmpTx;

  ram_loader #(.ADDR_WIDTH(AW), .RAM_RD_LATENCY(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_strobe (mem_wr_strobe),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data),
    .core_reset_n  (core_reset_n),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // RAM behind the port: filled with a known pattern, synchronous read.
  always @(posedge clk) begin
    if (!ramReady) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h5A5A0000 + 32'(i);
      ramReady <= 1'b1;
    end else if (mem_wr_en) begin
      ram[mem_addr] <= mem_wr_data;
    end
    rd1 <= ram[mem_addr];
    rd2 <= rd1;
  end
  assign mem_rd_data = (LAT == 1) ? rd1 : rd2;

  task automatic checkOutput(input string name, input logic [39:0] act,
                             input logic [39:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Command-level model: what the command does to pointer, RAM and output.
  task automatic modelCmd(input logic [7:0] op, input logic [31:0] w);
    logic [31:0] rd;
    logic        ack;
    ack = 1'b0;
    case (op)
      8'h01: begin mPtr = w; ack = 1'b1; end
      8'h02: begin
        expWr.push_back({mPtr[AW+1:2], w});
        mMem[mPtr[AW+1:2]] = w;
        mPtr = mPtr + 32'd4;
        ack = 1'b1;
      end
      8'h03: begin
        rd = mMem[mPtr[AW+1:2]];
        for (int i = 0; i < 4; i++) expTx.push_back(rd[8*i +: 8]);
        mPtr = mPtr + 32'd4;
      end
      8'h04: begin mCore = 1'b1; ack = 1'b1; end
      8'h05: begin mCore = 1'b0; ack = 1'b1; end
      default: expTx.push_back(8'hEE);
    endcase
`ifdef LOADER_ACK_EN
    if (ack) expTx.push_back(8'hAA);
`else
    if (ack) mPtr = mPtr;
`endif
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rx_accept", 40'(rx_ready), 40'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] w);
    sendByte(op);
    if (op == 8'h01 || op == 8'h02)
      for (int i = 0; i < 4; i++) sendByte(w[8*i +: 8]);
    modelCmd(op, w);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    expTx.delete();
    expWr.delete();
    mPtr  = 32'h0;
    mCore = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rx_ready", 40'(rx_ready), 40'd0);
    checkOutput("rst_tx_valid", 40'(tx_valid), 40'd0);
    checkOutput("rst_tx_data", 40'(tx_data), 40'd0);
    checkOutput("rst_wr_en", 40'(mem_wr_en), 40'd0);
    checkOutput("rst_strobe", 40'(mem_wr_strobe), 40'd0);
    checkOutput("rst_addr", 40'(mem_addr), 40'd0);
    checkOutput("rst_wr_data", 40'(mem_wr_data), 40'd0);
    checkOutput("rst_core", 40'(core_reset_n), 40'd0);
    checkOutput("rst_busy", 40'(busy), 40'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic waitQuiet();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || expTx.size() != 0 || expWr.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("quiet", 40'(n < 300), 40'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lastTxWord();
    int n;
    n = txLog.size();
    if (n < 4) return 32'hXXXXXXXX;
    return {txLog[n-1], txLog[n-2], txLog[n-3], txLog[n-4]};
  endfunction

  // Per-cycle monitor: every write and tx transfer against the model queues.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("strobe_rule", 40'(mem_wr_strobe), mem_wr_en ? 40'hF : 40'h0);
      checkOutput("core_state", 40'(core_reset_n), 40'(mCore));
      if (mem_wr_en) begin
        wrLog.push_back({mem_addr, mem_wr_data});
        if (expWr.size() == 0) begin
          checkOutput("unexpected_write", {mem_addr, mem_wr_data}, 40'h0);
        end else begin
          cmpWr = expWr.pop_front();
          checkOutput("wr_addr", 40'(mem_addr), 40'(cmpWr[39:32]));
          checkOutput("wr_data", 40'(mem_wr_data), 40'(cmpWr[31:0]));
        end
      end
      if (prevStall) begin
        checkOutput("tx_hold_valid", 40'(tx_valid), 40'd1);
        checkOutput("tx_hold_data", 40'(tx_data), 40'(prevData));
      end
      if (tx_valid && tx_ready) begin
        txLog.push_back(tx_data);
        if (expTx.size() == 0) begin
          checkOutput("unexpected_tx", 40'(tx_data), 40'h100);
        end else begin
          cmpTx = expTx.pop_front();
          checkOutput("tx_byte", 40'(tx_data), 40'(cmpTx));
        end
      end
      prevStall = tx_valid && !tx_ready;
      prevData  = tx_data;
    end else begin
      prevStall = 1'b0;
    end
  end

  initial begin
    int nW;
    int n;
    logic [7:0] held;
    for (int i = 0; i < 256; i++) mMem[i] = 32'h5A5A0000 + 32'(i);
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    mPtr     = 32'h0;
    mCore    = 1'b0;
    applyReset();

    // Write then read back, with latency checks.
    applyStimulus(8'h01, 32'h0);
    waitQuiet();
    applyStimulus(8'h02, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("wr_latency", 40'(mem_wr_en), 40'd1);
    waitQuiet();
    checkOutput("wr_first", wrLog[wrLog.size()-1], 40'h00DEADBEEF);
    applyStimulus(8'h01, 32'h0);
    waitQuiet();
    applyStimulus(8'h03, 32'h0);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      checkOutput("rd_lat_quiet", 40'(tx_valid), 40'd0);
    end
    @(negedge clk);
    checkOutput("rd_lat_first", 40'(tx_valid), 40'd1);
    waitQuiet();
    checkOutput("rd_back", 40'(lastTxWord()), 40'hDEADBEEF);
    checkOutput("ptr_after_rd", 40'(mem_addr), 40'd1);
    checkOutput("model_ptr", 40'(mPtr), 40'd4);

    // Auto-increment and wrap inside the 256-word RAM.
    nW = wrLog.size();
    applyStimulus(8'h01, 32'h000003FC);
    waitQuiet();
    applyStimulus(8'h02, 32'hCAFEF00D);
    waitQuiet();
    applyStimulus(8'h02, 32'h0BADF00D);
    waitQuiet();
    checkOutput("wrap_count", 40'(wrLog.size()), 40'(nW + 2));
    checkOutput("wrap_w0", wrLog[nW], 40'hFFCAFEF00D);
    checkOutput("wrap_w1", wrLog[nW+1], 40'h000BADF00D);

    // Backpressure on a read at word 1.
    tx_ready = 1'b0;
    applyStimulus(8'h03, 32'h0);
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_valid_seen", 40'(tx_valid), 40'd1);
    held = tx_data;
    checkOutput("bp_first_byte", 40'(held), 40'h01);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("bp_valid", 40'(tx_valid), 40'd1);
      checkOutput("bp_data", 40'(tx_data), 40'(held));
      checkOutput("bp_rx_ready", 40'(rx_ready), 40'd0);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    waitQuiet();
    checkOutput("bp_word", 40'(lastTxWord()), 40'h5A5A0001);

    // Illegal opcode, then a normal read still works.
    nW = wrLog.size();
    applyStimulus(8'h7F, 32'h0);
    waitQuiet();
    checkOutput("err_byte", 40'(txLog[txLog.size()-1]), 40'hEE);
    checkOutput("err_no_write", 40'(wrLog.size()), 40'(nW));
    applyStimulus(8'h03, 32'h0);
    waitQuiet();
    checkOutput("after_err_rd", 40'(lastTxWord()), 40'h5A5A0002);

    // Core control.
    applyStimulus(8'h04, 32'h0);
    waitQuiet();
    checkOutput("run", 40'(core_reset_n), 40'd1);
    applyStimulus(8'h05, 32'h0);
    waitQuiet();
    checkOutput("halt", 40'(core_reset_n), 40'd0);
    applyStimulus(8'h04, 32'h0);
    waitQuiet();
    applyStimulus(8'h04, 32'h0);
    waitQuiet();
    checkOutput("run_again", 40'(core_reset_n), 40'd1);
    applyReset();

    // Reset in the middle of a WRITE: no write, RAM keeps old word.
    nW = wrLog.size();
    sendByte(8'h02);
    sendByte(8'h11);
    sendByte(8'h22);
    applyReset();
    checkOutput("partial_no_write", 40'(wrLog.size()), 40'(nW));
    applyStimulus(8'h03, 32'h0);
    waitQuiet();
    checkOutput("partial_rd", 40'(lastTxWord()), 40'h0BADF00D);
    checkOutput("partial_ptr", 40'(mem_addr), 40'd1);
    checkOutput("partial_wr_count", 40'(wrLog.size()), 40'(nW));

    checkOutput("exp_tx_drained", 40'(expTx.size()), 40'd0);
    checkOutput("exp_wr_drained", 40'(expWr.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
